// File: rtl/lns_to_fixed.sv
`default_nettype none
//==============================================================================
// Module      : lns_to_fixed
// Description : Three-stage pipelined decoder from signed base-2 LNS
//               (log magnitude + sign) to rounded, saturated signed
//               linear fixed point, with a global valid/ready stall.
// Revision    : 1.0 - initial release
//==============================================================================
module lns_to_fixed #(
   parameter int IN_W     = 18,
   parameter int FRAC     = 9,
   parameter int OUT_W    = 32,
   parameter int OUT_FRAC = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  X,
   input  logic             Sx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] Z,
   output logic             ovf,
   output logic             unf
);

   localparam int                    c_kw        = IN_W - FRAC;
   localparam int                    c_sw        = ((c_kw > 10) ? c_kw : 10) + 2;
   localparam logic [IN_W-1:0]       c_zero_code = {1'b1, {(IN_W-1){1'b0}}};
   localparam logic signed [c_sw-1:0] c_soff     = c_sw'(OUT_FRAC - 16);
   localparam logic signed [c_sw-1:0] c_max_ls   = c_sw'(OUT_W - 18);
   localparam logic [c_sw-1:0]       c_rmax      = c_sw'(18);
   localparam logic [OUT_W-1:0]      c_sat       = {1'b0, {(OUT_W-1){1'b1}}};

   // Floor square root of a 128-bit value, classic bit-pair method.
   function automatic logic [127:0] isqrt(input logic [127:0] v);
      logic [127:0] rem;
      logic [127:0] res;
      logic [127:0] one;
      rem = v;
      res = '0;
      one = 128'd1 << 126;
      for (int i = 0; i < 64; i++) begin
         if (rem >= res + one) begin
            rem = rem - (res + one);
            res = (res >> 1) + one;
         end else begin
            res = res >> 1;
         end
         one = one >> 2;
      end
      return res;
   endfunction

   // round(2^(f/2^FRAC) * 2^16): product of repeated square roots of 2,
   // carried in Q.60 so the final rounding to 16 fraction bits is exact.
   function automatic logic [16:0] exp_frac(input logic [FRAC-1:0] f);
      logic [127:0] acc;
      logic [127:0] root;
      acc  = 128'd1 << 60;
      root = 128'd2 << 60;
      for (int j = FRAC - 1; j >= 0; j--) begin
         root = isqrt(root << 60);
         if (f[j]) begin
            acc = (acc * root) >> 60;
         end
      end
      return 17'((acc + (128'd1 << 43)) >> 44);
   endfunction

   logic              w_adv;
   logic [16:0]       w_rom [2**FRAC];

   logic              r1_valid;
   logic              r1_zero;
   logic              r1_sx;
   logic [c_kw-1:0]   r1_k;
   logic [16:0]       r1_m;

   logic signed [c_sw-1:0] w_s;
   logic [c_sw-1:0]   w_r;
   logic [17:0]       w_sum;
   logic [17:0]       w_shr;
   logic [OUT_W-1:0]  w_mag;
   logic              w_ovf;
   logic              w_unf;

   logic              r2_valid;
   logic              r2_sx;
   logic [OUT_W-1:0]  r2_mag;
   logic              r2_ovf;
   logic              r2_unf;

   logic              r_out_valid;
   logic [OUT_W-1:0]  r_z;
   logic              r_ovf;
   logic              r_unf;

   // Mantissa table, every entry a constant resolved at elaboration.
   for (genvar gi = 0; gi < 2**FRAC; gi++) begin : g_rom
      assign w_rom[gi] = exp_frac(FRAC'(gi));
   end

   // The whole pipeline moves together unless the output is held.
   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = w_adv;

   // Stage 1: capture sign, zero code, integer exponent and table mantissa.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r1_valid <= 1'b0;
         r1_zero  <= 1'b0;
         r1_sx    <= 1'b0;
         r1_k     <= '0;
         r1_m     <= '0;
      end else if (w_adv) begin
         r1_valid <= in_valid;
         r1_zero  <= (X == c_zero_code);
         r1_sx    <= Sx;
         r1_k     <= X[IN_W-1:FRAC];
         r1_m     <= w_rom[X[FRAC-1:0]];
      end
   end

   // Stage 2 logic: shift the mantissa into place, rounding right shifts
   // half-up and clamping left shifts that would overflow the output.
   always_comb begin
      w_s   = {{(c_sw-c_kw){r1_k[c_kw-1]}}, r1_k} + c_soff;
      w_r   = '0;
      w_sum = '0;
      w_shr = '0;
      w_mag = '0;
      w_ovf = 1'b0;
      w_unf = 1'b0;
      if (r1_zero) begin
         w_mag = '0;
      end else if (!w_s[c_sw-1]) begin
         if (w_s > c_max_ls) begin
            w_mag = c_sat;
            w_ovf = 1'b1;
         end else begin
            w_mag = {{(OUT_W-17){1'b0}}, r1_m} << $unsigned(w_s);
         end
      end else begin
         w_r = -w_s;
         if (w_r < c_rmax) begin
            w_sum = {1'b0, r1_m} + (18'd1 << (w_r - 1'b1));
            w_shr = w_sum >> w_r;
            w_mag = {{(OUT_W-18){1'b0}}, w_shr};
         end
         w_unf = (w_mag == '0);
      end
   end

   // Stage 2: register unsigned magnitude and flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r2_valid <= 1'b0;
         r2_sx    <= 1'b0;
         r2_mag   <= '0;
         r2_ovf   <= 1'b0;
         r2_unf   <= 1'b0;
      end else if (w_adv) begin
         r2_valid <= r1_valid;
         r2_sx    <= r1_sx;
         r2_mag   <= w_mag;
         r2_ovf   <= w_ovf;
         r2_unf   <= w_unf;
      end
   end

   // Stage 3: apply sign; magnitude never exceeds 2^(OUT_W-1)-1 so the
   // negation is symmetric and a zero magnitude stays zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_z         <= '0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= r2_valid;
         r_z         <= r2_sx ? -r2_mag : r2_mag;
         r_ovf       <= r2_ovf;
         r_unf       <= r2_unf;
      end
   end

   assign out_valid = r_out_valid;
   assign Z         = r_z;
   assign ovf       = r_ovf;
   assign unf       = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_lns_to_fixed.sv
`default_nettype none
//==============================================================================
// Module      : tb_lns_to_fixed
// Description : Self-checking bench for lns_to_fixed: directed values,
//               backpressure, randomized streaming against a real-number
//               reference model, and reset with items in flight.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_lns_to_fixed;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] X;
   logic        Sx;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Z;
   logic        ovf;
   logic        unf;

   always #5 clk = ~clk;

   lns_to_fixed dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .X         (X),
      .Sx        (Sx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Z         (Z),
      .ovf       (ovf),
      .unf       (unf)
   );

   typedef struct {
      logic [31:0] z;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   received = 0;
   int   sent     = 0;
   int   stall    = 0;
   bit   seen     = 0;
   bit   pending  = 0;
   bit   prev_st  = 0;
   logic [31:0] held;

   // Reference: value = 2^(X/512), rounded to 16 fraction bits, clamped.
   function automatic exp_t model(input logic [17:0] x, input logic sx);
      exp_t   e;
      longint xi, f, k, m, mag;
      real    v;
      e.z = '0; e.ovf = 1'b0; e.unf = 1'b0;
      if (x == 18'h20000) return e;
      xi = longint'($signed(x));
      f  = longint'(x[8:0]);
      k  = (xi - f) / 512;
      m  = longint'($floor($pow(2.0, real'(f) / 512.0) * 65536.0 + 0.5));
      if (k >= 0) v = real'(m) * $pow(2.0, real'(k));
      else        v = $floor(real'(m) / $pow(2.0, real'(-k)) + 0.5);
      if (v > 2147483647.0) begin
         mag   = 64'sd2147483647;
         e.ovf = 1'b1;
      end else begin
         mag = longint'(v);
      end
      e.unf = (mag == 0);
      e.z   = 32'(sx ? -mag : mag);
      return e;
   endfunction

   function automatic logic [17:0] rand_x();
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) return 18'h20000;
      if (sel <= 2) return 18'($urandom);
      return 18'((int'($urandom_range(0, 40)) - 22) * 512 + int'($urandom_range(0, 511)));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Score transfers seen before the next rising edge, then advance a cycle.
   task automatic tick();
      exp_t e;
      #1;
      if (out_valid && out_ready) begin
         checks++;
         assert (q.size() != 0) else begin
            errors++;
            $error("FAIL spurious_output: observed Z=%h with nothing pending, expected no output", Z);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            received++;
            chk("stream_Z", Z, e.z);
            chk1("stream_ovf", ovf, e.ovf);
            chk1("stream_unf", unf, e.unf);
         end
      end
      if (in_valid && in_ready) q.push_back(model(X, Sx));
      @(posedge clk);
      @(negedge clk);
   endtask

   // One isolated item: checks acceptance, 3-cycle latency, value, drain.
   task automatic single(input string tag, input logic [17:0] x, input logic sx,
                         input logic [31:0] ez, input logic eo, input logic eu);
      X = x; Sx = sx; in_valid = 1'b1; out_ready = 1'b1;
      #1 chk1({tag, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      chk1({tag, "_lat1"}, out_valid, 1'b0);
      @(posedge clk); @(negedge clk);
      chk1({tag, "_lat2"}, out_valid, 1'b0);
      @(posedge clk); @(negedge clk);
      chk1({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_Z"}, Z, ez);
      chk1({tag, "_ovf"}, ovf, eo);
      chk1({tag, "_unf"}, unf, eu);
      @(posedge clk); @(negedge clk);
      chk1({tag, "_drain"}, out_valid, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; X = '0; Sx = 1'b0;
      repeat (2) @(negedge clk);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk("rst_Z", Z, 32'h0);
      chk1("rst_ovf", ovf, 1'b0);
      chk1("rst_unf", unf, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed values
      single("one",      18'h00000, 1'b0, 32'h00010000, 1'b0, 1'b0);
      single("two",      18'h00200, 1'b0, 32'h00020000, 1'b0, 1'b0);
      single("sqrt2",    18'h00100, 1'b0, 32'h00016A0A, 1'b0, 1'b0);
      single("nsqrt2",   18'h00100, 1'b1, 32'hFFFE95F6, 1'b0, 1'b0);
      single("zero_p",   18'h20000, 1'b0, 32'h00000000, 1'b0, 1'b0);
      single("zero_n",   18'h20000, 1'b1, 32'h00000000, 1'b0, 1'b0);
      single("max_nsat", 18'h01C00, 1'b0, 32'h40000000, 1'b0, 1'b0);
      single("sat_p",    18'h01E00, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
      single("sat_n",    18'h01E00, 1'b1, 32'h80000001, 1'b1, 1'b0);
      single("rnd_one",  18'h3DE00, 1'b0, 32'h00000001, 1'b0, 1'b0);
      single("unf",      18'h3DC00, 1'b0, 32'h00000000, 1'b0, 1'b1);
      single("half",     18'h3FE00, 1'b0, 32'h00008000, 1'b0, 1'b0);

      // Backpressure: 6 inputs, output held for 5 cycles after first valid
      received = 0; sent = 0; stall = 0; seen = 0; pending = 0; prev_st = 0;
      for (int c = 0; c < 60 && received < 6; c++) begin
         if (!pending) begin
            X = rand_x(); Sx = 1'($urandom_range(0, 1));
         end
         in_valid = (sent < 6);
         if (out_valid) seen = 1;
         out_ready = !(seen && stall < 5);
         #1;
         if (!out_ready) begin
            stall++;
            chk1("bp_in_ready_low", in_ready, 1'b0);
            if (prev_st) chk("bp_hold_Z", Z, held);
            held = Z;
            prev_st = 1;
         end else begin
            prev_st = 0;
         end
         pending = in_valid && !in_ready;
         if (in_valid && in_ready) sent++;
         tick();
      end
      chk("bp_count", 32'(received), 32'd6);
      chk("bp_empty", 32'(q.size()), 32'd0);

      // Randomized streaming with random valid and ready
      in_valid = 1'b0; received = 0; sent = 0; pending = 0;
      for (int c = 0; c < 400; c++) begin
         if (!pending) begin
            X = rand_x(); Sx = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         pending = in_valid && !in_ready;
         if (in_valid && in_ready) sent++;
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 10 && q.size() != 0; c++) tick();
      chk("rand_drain", 32'(q.size()), 32'd0);
      chk("rand_count", 32'(received), 32'(sent));

      // Reset with three items in flight
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         X = rand_x(); Sx = 1'($urandom_range(0, 1));
         @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      chk1("full_out_valid", out_valid, 1'b1);
      chk1("full_in_ready", in_ready, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      chk1("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_Z", Z, 32'h0);
      chk1("mid_rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      q.delete();
      single("post_rst", 18'h00000, 1'b0, 32'h00010000, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         chk1("post_rst_idle", out_valid, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lns_to_fixed.md
# lns_to_fixed

Pipelined decoder from the 18-bit base-2 logarithmic number system (LNS) back to signed linear fixed-point. It is the inverse end of the LNS datapath: operands produced by the log-domain adders and multipliers are converted here for output or comparison against linear references. It accepts one LNS word per cycle on a valid/ready handshake and produces the rounded, saturated linear value after three pipeline stages.

## Interface
Parameters:
- IN_W, 18: LNS log-magnitude width, two's complement.
- FRAC, 9: fractional bits of the log magnitude.
- OUT_W, 32: linear output width, two's complement.
- OUT_FRAC, 16: fractional bits of the linear output.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  X/Sx valid.
- in_ready  out  1  stage 1 accepts this cycle.
- X  in  IN_W  signed log2 magnitude, Q(IN_W-FRAC).FRAC.
- Sx  in  1  sign, 1 = negative.
- out_valid  out  1  Z/ovf/unf valid.
- out_ready  in  1  downstream accepts.
- Z  out  OUT_W  signed linear result, Q(OUT_W-OUT_FRAC).OUT_FRAC.
- ovf  out  1  result saturated.
- unf  out  1  nonzero input rounded to 0.

## Operation
- Zero code: X == -2^(IN_W-1) means the value is zero. Output Z=0, ovf=0, unf=0.
- Split X: k = X>>>FRAC (signed integer), f = X[FRAC-1:0].
- Mantissa: M = ExpFrac[f], a 2^FRAC-entry ROM from the Tables include. Entry is round(2^(f/2^FRAC) * 2^16), 17-bit unsigned, range 65536..131071.
- Shift: s = k + OUT_FRAC - 16, signed, at least 10 bits.
- s >= 0: mag = M << s. If s > OUT_W-18, then mag = 2^(OUT_W-1)-1 and ovf=1.
- s < 0: r = -s and mag = (M + 2^(r-1)) >> r, round half up. For r >= 18, mag = 0. If mag == 0, unf=1.
- Sign: Z = Sx ? -mag : mag. Saturation is symmetric at ±(2^(OUT_W-1)-1). -0 yields 0.
- Stage 1: register X/Sx/zero flag, synchronous ROM read of M, register k.
- Stage 2: compute s, shift/round/saturate, register mag, ovf, unf.
- Stage 3: apply sign, register Z/ovf/unf, out_valid.

## Timing
- Global stall: adv = !out_valid || out_ready; in_ready = adv (combinational).
- Each stage carries a valid bit. All stages load only when adv=1. Bubbles propagate as invalid stages.
- A transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
- Latency is 3 cycles from input transfer to out_valid when unstalled. Throughput is 1 per cycle.
- While out_valid && !out_ready, Z/ovf/unf hold stable and no stage changes. The pipeline holds up to 3 items. None are dropped or duplicated.
- Reset, synchronous with rst_n=0 at a clock edge: all valid bits 0, Z=0, ovf=0, unf=0, out_valid=0.
- in_ready=1 during and after reset because out_valid=0.
- Reset mid-stream discards all in-flight items. The first accepted input after reset appears 3 cycles later.
- Simultaneous output consume and input accept in the same cycle is legal and is the steady state.
- Output flags are valid only with out_valid.

## Test plan
- X=0x00000, Sx=0 -> Z=0x00010000. X=0x00200 -> Z=0x00020000. X=0x00100 -> Z=92682 (0x00016A0A). Each appears 3 cycles after accept.
- X=0x00100, Sx=1 -> Z=-92682 (0xFFFE95F6). X=0x20000 with either sign -> Z=0, no flags.
- Saturation: X=14<<9 -> Z=0x40000000, ovf=0. X=15<<9 -> Z=0x7FFFFFFF, ovf=1. Same with Sx=1 -> Z=0x80000001, ovf=1.
- Rounding/underflow: X=-17<<9 -> Z=1, unf=0. X=-18<<9 -> Z=0, unf=1. X=(-1<<9) -> Z=0x00008000.
- Backpressure: stream 6 consecutive inputs. Hold out_ready=0 for 5 cycles after the first out_valid. in_ready drops while the pipeline is full. Z holds. All 6 results arrive in order with no loss or duplication.
- Reset with 3 items in flight: out_valid=0 the next cycle with Z=0. A new input X=0 yields Z=0x00010000 exactly 3 cycles after accept, and no stale data appears.
